// File: rtl/zx81_tape_pkg.sv
// Shared state codes, pulse counts and timing defaults for the ZX81 tape player.
// Build macro TAPE_LEADER_EN adds the pre-roll leader and widens the shared timer to 22 bits.
package zx81_tape_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEADER  = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_PULSE_H = 3'd3;
  localparam logic [2:0] ST_PULSE_L = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [3:0] PULSES_ZERO = 4'd4;
  localparam logic [3:0] PULSES_ONE  = 4'd9;

  localparam int DEF_PULSE_CYC = 975;
  localparam int DEF_GAP_CYC   = 8450;

`ifdef TAPE_LEADER_EN
  localparam int TMR_W = 22;
`else
  localparam int TMR_W = 14;
`endif

  function automatic logic [3:0] pulses_for(input logic bit_val);
    return bit_val ? PULSES_ONE : PULSES_ZERO;
  endfunction

endpackage

// File: rtl/tape_pulse_timer.sv
// Loadable down-counter shared by the leader, pulse and gap phases.
// Load N-1 to get an N-clock interval; expire is high while the count sits at zero.
module tape_pulse_timer #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/zx81_tape_player.sv
// Replays a stored .P image from SRAM as ZX81 tape pulse trains on tape_out (MSB first, 4/9 pulses per bit).
// Build macro TAPE_LEADER_EN inserts a LEADER_CYC silent pre-roll before the first fetch.
module zx81_tape_player
  import zx81_tape_pkg::*;
#(
  parameter int ADDR_W     = 21,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
`ifdef TAPE_LEADER_EN
  parameter int LEADER_CYC = 3250000,
`endif
  parameter int RD_WAIT    = 2
) (
  input  logic              clk65,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);

  localparam int WC_W = $clog2(RD_WAIT + 2);

  logic [2:0]        state;
  logic              play_d1, play_d2;
  logic              play_rise, start, capture;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       remaining;
  logic [6:0]        shreg;
  logic [2:0]        bit_cnt;
  logic [3:0]        pulse_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic              tmr_load, tmr_exp;
  logic [TMR_W-1:0]  tmr_val;

  assign play_rise = play_d1 & ~play_d2;
  assign start     = play_rise & ~stop & (length != 16'd0);
  assign capture   = (state == ST_FETCH) & mem_gnt & (wait_cnt == WC_W'(RD_WAIT));
  assign mem_addr  = addr;

  tape_pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk65),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
`ifdef TAPE_LEADER_EN
      ST_IDLE: if (start) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(LEADER_CYC - 1);
      end
`endif
      ST_FETCH: if (capture) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(PULSE_CYC - 1);
      end
      ST_PULSE_H: if (tmr_exp) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(PULSE_CYC - 1);
      end
      ST_PULSE_L: if (tmr_exp) begin
        tmr_load = 1'b1;
        tmr_val  = (pulse_cnt == 4'd1) ? TMR_W'(GAP_CYC - 1) : TMR_W'(PULSE_CYC - 1);
      end
      ST_GAP: if (tmr_exp && bit_cnt != 3'd0) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(PULSE_CYC - 1);
      end
      default: ;
    endcase
  end

  // Edge history resets to "already high" so a play level held through reset is not taken as a new start.
  always_ff @(posedge clk65 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      play_d1   <= 1'b1;
      play_d2   <= 1'b1;
      addr      <= '0;
      remaining <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      pulse_cnt <= '0;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      tape_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      play_d1  <= play;
      play_d2  <= play_d1;
      done     <= 1'b0;
      wait_cnt <= '0;
      if (stop && state != ST_IDLE) begin
        state    <= ST_IDLE;
        mem_req  <= 1'b0;
        tape_out <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (play_rise && !stop && length == 16'd0) begin
              done <= 1'b1;
            end else if (start) begin
              addr      <= base_addr;
              remaining <= length;
              busy      <= 1'b1;
`ifdef TAPE_LEADER_EN
              state     <= ST_LEADER;
`else
              state     <= ST_FETCH;
              mem_req   <= 1'b1;
`endif
            end
          end
`ifdef TAPE_LEADER_EN
          ST_LEADER: if (tmr_exp) begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
          end
`endif
          ST_FETCH: begin
            // Losing the grant before capture restarts the read-wait count.
            if (capture) begin
              shreg     <= mem_data[6:0];
              bit_cnt   <= 3'd7;
              pulse_cnt <= pulses_for(mem_data[7]);
              mem_req   <= 1'b0;
              tape_out  <= 1'b1;
              state     <= ST_PULSE_H;
            end else if (mem_gnt) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_PULSE_H: if (tmr_exp) begin
            tape_out <= 1'b0;
            state    <= ST_PULSE_L;
          end
          ST_PULSE_L: if (tmr_exp) begin
            if (pulse_cnt == 4'd1) begin
              state <= ST_GAP;
            end else begin
              pulse_cnt <= pulse_cnt - 1'b1;
              tape_out  <= 1'b1;
              state     <= ST_PULSE_H;
            end
          end
          ST_GAP: if (tmr_exp) begin
            if (bit_cnt != 3'd0) begin
              shreg     <= {shreg[5:0], 1'b0};
              bit_cnt   <= bit_cnt - 1'b1;
              pulse_cnt <= pulses_for(shreg[6]);
              tape_out  <= 1'b1;
              state     <= ST_PULSE_H;
            end else if (remaining != 16'd1) begin
              addr      <= addr + 1'b1;
              remaining <= remaining - 1'b1;
              mem_req   <= 1'b1;
              state     <= ST_FETCH;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
